// File: rtl/fetch_queue.sv
// fetch_queue: circular instruction queue between the fetch and decode stages.
//
// Parameters
//   DEPTH      number of {pc, inst} entries (2, 4, 8 or 16)
//
// Ports
//   clk        sole clock, all state updates on the rising edge
//   resetn     asynchronous active-low reset (clears pointers and count)
//   flush      branch redirect; drops queued and same-cycle instructions
//   in_valid   fetched instruction present on in_pc / in_inst
//   in_pc      PC of the fetched instruction
//   in_inst    fetched instruction word
//   in_ready   queue accepts a push this cycle
//   out_valid  head entry available to the decoder
//   out_pc     PC of the head entry
//   out_inst   instruction of the head entry
//   out_ready  decoder consumes the head this cycle
//   count      number of occupied entries
//
// Build option
//   FQ_BYPASS_EN  when defined, an empty queue forwards in_* straight to out_*;
//                 if the decoder takes it that cycle the entry is never written.
module fetch_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [31:0]                in_pc,
  input  logic [31:0]                in_inst,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [31:0]                out_pc,
  output logic [31:0]                out_inst,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(DEPTH - 1);

  // Storage is intentionally not reset; only pointers and count are.
  logic [63:0]     mem_q [DEPTH];
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic empty;
  logic full;
  logic bypass_take;
  logic push;
  logic pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CntFull);

  assign in_ready = ~full & ~flush;
  assign count    = count_q;

`ifdef FQ_BYPASS_EN
  // Empty queue: present the incoming instruction directly to the decoder.
  always_comb begin
    if (empty) begin
      out_valid = in_valid & ~flush;
      out_pc    = in_pc;
      out_inst  = in_inst;
    end else begin
      out_valid = ~flush;
      out_pc    = mem_q[rd_ptr_q][63:32];
      out_inst  = mem_q[rd_ptr_q][31:0];
    end
  end
  assign bypass_take = empty & in_valid & out_ready & ~flush;
`else
  always_comb begin
    out_valid = ~empty & ~flush;
    out_pc    = mem_q[rd_ptr_q][63:32];
    out_inst  = mem_q[rd_ptr_q][31:0];
  end
  assign bypass_take = 1'b0;
`endif

  // A bypassed instruction is consumed without touching storage.
  assign push = in_valid & in_ready & ~bypass_take;
  assign pop  = out_valid & out_ready & ~empty;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_q[wr_ptr_q] <= {in_pc, in_inst};
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_ready;
  logic [$clog2(DEPTH):0] count;

  int checks = 0;
  int failures = 0;

  // Reference: queue of {pc, inst} in push order.
  logic [63:0] model_q[$];

`ifdef FQ_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_pc     (in_pc),
    .in_inst   (in_inst),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_pc    (out_pc),
    .out_inst  (out_inst),
    .out_ready (out_ready),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, clock, update model.
  task automatic cyc(input logic fl, input logic iv, input logic [31:0] pc,
                     input logic [31:0] inst, input logic ordy);
    logic        e_in_ready;
    logic        e_out_valid;
    logic [63:0] e_head;
    logic        byp;
    flush = fl; in_valid = iv; in_pc = pc; in_inst = inst; out_ready = ordy;
    #1;
    e_in_ready = (model_q.size() != DEPTH) && !fl;
    e_head = '0;
    byp = 1'b0;
    if (fl) begin
      e_out_valid = 1'b0;
    end else if (model_q.size() > 0) begin
      e_out_valid = 1'b1;
      e_head = model_q[0];
    end else if (Bypass) begin
      e_out_valid = iv;
      e_head = {pc, inst};
      byp = iv && ordy;
    end else begin
      e_out_valid = 1'b0;
    end
    chk("in_ready", 32'(in_ready), 32'(e_in_ready));
    chk("out_valid", 32'(out_valid), 32'(e_out_valid));
    chk("count", 32'(count), model_q.size());
    if (e_out_valid) begin
      chk("out_pc", out_pc, e_head[63:32]);
      chk("out_inst", out_inst, e_head[31:0]);
    end
    @(posedge clk);
    if (fl) begin
      model_q.delete();
    end else begin
      if (e_out_valid && ordy && model_q.size() > 0) void'(model_q.pop_front());
      if (iv && e_in_ready && !byp) model_q.push_back({pc, inst});
    end
    #1;
  endtask

  initial begin
    resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_inst = '0; out_ready = 1'b0;
    #12;
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    resetn = 1'b1;
    @(posedge clk); #1;

    // Fill to DEPTH, then a fifth push that must be ignored.
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b1, 32'hBFC0_0000 + 32'(4 * i), 32'h1000_0000 + 32'(i), 1'b0);
    end
    chk("full_count", 32'(count), 32'd4);
    chk("full_in_ready", 32'(in_ready), 32'd0);

    // Drain in order.
    for (int i = 0; i < 4; i++) begin
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; #1;
      chk("drain_pc", out_pc, 32'hBFC0_0000 + 32'(4 * i));
      cyc(1'b0, 1'b0, '0, '0, 1'b1);
    end
    chk("drained_count", 32'(count), 32'd0);
    chk("drained_out_valid", 32'(out_valid), 32'd0);

    // Steady stream at count=2 with pointer wrap.
    cyc(1'b0, 1'b1, 32'hBFC0_0020, 32'h2, 1'b0);
    cyc(1'b0, 1'b1, 32'hBFC0_0024, 32'h3, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b1, 32'hBFC0_0028 + 32'(4 * i), 32'h100 + 32'(i), 1'b1);
      chk("stream_count", 32'(count), 32'd2);
    end

    // Flush with count=3 and a same-cycle push.
    cyc(1'b0, 1'b1, 32'hBFC0_0080, 32'h80, 1'b0);
    chk("preflush_count", 32'(count), 32'd3);
    cyc(1'b1, 1'b1, 32'hBFC0_0084, 32'h84, 1'b1);
    chk("postflush_count", 32'(count), 32'd0);
    cyc(1'b0, 1'b1, 32'hBFC0_0100, 32'h1234_5678, 1'b0);
    chk("postflush_head", out_pc, 32'hBFC0_0100);
    cyc(1'b0, 1'b0, '0, '0, 1'b1);

    // Push into empty with out_ready=1: bypass or one-cycle latency.
    cyc(1'b0, 1'b1, 32'hBFC0_0200, 32'hCAFE_0200, 1'b1);
    cyc(1'b0, 1'b0, '0, '0, 1'b1);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 19) == 0), 1'($urandom), $urandom, $urandom, 1'($urandom));
    end

    // Asynchronous reset between edges with count=3.
    cyc(1'b1, 1'b0, '0, '0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 32'hBFC0_0300 + 32'(4 * i), 32'(i), 1'b0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("pre_reset_count", 32'(count), 32'd3);
    #2 resetn = 1'b0;
    #1;
    chk("async_reset_count", 32'(count), 32'd0);
    chk("async_reset_out_valid", 32'(out_valid), 32'd0);
    model_q.delete();
    #1 resetn = 1'b1;
    @(posedge clk); #1;
    cyc(1'b0, 1'b1, 32'hBFC0_0400, 32'h400, 1'b0);
    cyc(1'b0, 1'b0, '0, '0, 1'b1);
    cyc(1'b0, 1'b0, '0, '0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of entries; legal values 2, 4, 8, 16.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port flush  input  1  branch redirect from the execute stage; discards all queued and incoming instructions.
REQ-005 SHALL have port in_valid  input  1  fetched instruction present on in_pc/in_inst.
REQ-006 SHALL have port in_pc  input  32  PC of the fetched instruction.
REQ-007 SHALL have port in_inst  input  32  instruction word from inst_sram_rdata.
REQ-008 SHALL have port in_ready  output  1  queue accepts a push this cycle.
REQ-009 SHALL have port out_valid  output  1  head entry available to the decoder.
REQ-010 SHALL have port out_pc  output  32  PC of the head entry.
REQ-011 SHALL have port out_inst  output  32  instruction of the head entry.
REQ-012 SHALL have port out_ready  input  1  decoder consumes the head this cycle.
REQ-013 SHALL have port count  output  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-014 SHALL store {pc, inst} entries in a circular buffer with read pointer, write pointer ($clog2(DEPTH) bits each, wrapping DEPTH-1 -> 0) and occupancy counter 0..DEPTH.
REQ-015 SHALL push when in_valid & in_ready; SHALL pop when out_valid & out_ready.
REQ-016 SHALL drive in_ready = (count != DEPTH) & ~flush; in_ready SHALL NOT depend on out_ready (no push into a full queue, even with a same-cycle pop).
REQ-017 SHALL drive out_valid = (count != 0) & ~flush; out_pc/out_inst SHALL come from the read-pointer entry combinationally.
REQ-018 SHALL on a simultaneous push and pop with 0 < count < DEPTH keep count unchanged and advance both pointers.
REQ-019 SHALL, on flush=1, set count, rd_ptr, wr_ptr to 0 at the next edge and drop any same-cycle push or pop; flush overrides all other events.
REQ-020 SHALL deliver entries in push order with no loss or duplication.
REQ-021 SHALL give a push-to-out_valid latency of 1 cycle when built without FQ_BYPASS_EN.
REQ-022 SHALL leave storage contents unchanged on pop or flush; only the pointers and the counter move.

Reset
REQ-023 SHALL, while resetn=0, asynchronously clear rd_ptr, wr_ptr and count to 0.
REQ-024 SHALL hold out_valid=0, in_ready=1 (flush=0) and count=0 from reset assertion until the first push.
REQ-025 SHALL NOT reset the storage array; out_pc/out_inst are don't-care while out_valid=0.
REQ-026 SHALL, on reset asserted mid-operation, lose all queued entries, with no pop or push completing in that cycle.

Configuration
REQ-027 SHALL support macro FQ_BYPASS_EN.
REQ-028 With FQ_BYPASS_EN defined, when count=0 and flush=0, out_valid SHALL equal in_valid and out_pc/out_inst SHALL equal in_pc/in_inst.
REQ-029 With FQ_BYPASS_EN defined and out_ready=1 in that bypass cycle, the instruction SHALL NOT be written and count SHALL stay 0.
REQ-030 With FQ_BYPASS_EN defined and out_ready=0 in that bypass cycle, the instruction SHALL be written normally.
REQ-031 Without FQ_BYPASS_EN, REQ-017 and REQ-021 SHALL apply unchanged.

Verification
REQ-032 Fill: DEPTH=4, out_ready=0, push pc 0xBFC00000..0xBFC0000C -> count=4, in_ready=0; a 5th push (pc 0xBFC00010) is ignored.
REQ-033 Drain order: after REQ-032, out_ready=1 for 4 cycles -> out_pc 0xBFC00000, 04, 08, 0C in order; then out_valid=0, count=0.
REQ-034 Steady stream: count=2, push and pop every cycle for 10 cycles -> count stays 2, pointers wrap, order is preserved.
REQ-035 Flush: count=3, push in flush cycle -> in_ready=0 and out_valid=0 that cycle; next cycle count=0; a subsequent push of 0xBFC00100 is the next output.
REQ-036 Bypass: FQ_BYPASS_EN defined, empty queue, in_valid=1, in_pc=0xBFC00200, out_ready=1 -> out_valid=1, out_pc=0xBFC00200 same cycle, count stays 0; without the macro, out_valid=1 one cycle later.
REQ-037 Async reset: resetn low between clock edges while count=3 -> count=0 and out_valid=0 immediately, without waiting for an edge.
